dmem_access_ctrl: RTL and testbench

Sequences a variable-latency data-memory access for the Memory stage of the 5-stage RISC-V pipeline. It accepts a load or store from M, drives a req/ack memory handshake, and freezes F/D/E/M while the access is outstanding. It inserts a bubble into the M/W pipeline register during the stall and returns registered read data to the M/W boundary. It also provides an access timeout fault and a stall-cycle performance counter.

---
 rtl/dmem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Memory-stage data access sequencer for a 5-stage RISC-V
//               pipeline.
//
//               A load or store seen in M while idle is launched as a
//               registered req/ack transaction. F/D/E/M are frozen and a
//               bubble is pushed into M/W until the access completes. Load
//               data is returned registered to the M/W boundary. An access
//               that sees no ack within TIMEOUT request cycles is aborted
//               with a one-cycle fault pulse. A saturating counter records
//               the number of stall cycles.
//
// Ports       : clk, reset                 clock, synchronous active-high reset
//               MemReadM, MemWriteM        M-stage load / store strobes
//               ALUResultM, WriteDataM,    M-stage address, store data and
//               ByteEnM                    byte lanes
//               mem_req/we/addr/wdata/be   registered memory request
//               mem_ack, mem_rdata         memory completion pulse and data
//               ReadDataM                  registered load data
//               StallM, FlushW             pipeline freeze / M-W bubble
//               FaultM                     access-timeout pulse
//               StallCnt                   saturating stall-cycle counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [31:0]      ALUResultM,
    input  logic [31:0]      WriteDataM,
    input  logic [3:0]       ByteEnM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      ReadDataM,
    output logic             StallM,
    output logic             FlushW,
    output logic             FaultM,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Timer value of the final request cycle before the access is abandoned.
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [7:0]       r_timer;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_read_data;
    logic             r_fault;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_access;
    logic             w_stall;

    assign w_access = MemReadM | MemWriteM;

    // The stall covers the IDLE cycle that launches the access plus every
    // REQ cycle. DONE releases the pipeline so the instruction moves into W
    // together with the freshly registered load data.
    assign w_stall = !reset &&
                     (((r_state == c_IDLE) && w_access) || (r_state == c_REQ));

    assign StallM    = w_stall;
    assign FlushW    = w_stall;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign ReadDataM = r_read_data;
    assign FaultM    = r_fault;
    assign StallCnt  = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_timer     <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            r_read_data <= 32'd0;
            r_fault     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // Fault is only ever set on the REQ->DONE edge, so clearing it
            // by default limits it to exactly the DONE cycle.
            r_fault <= 1'b0;

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            case (r_state)
                c_IDLE: begin
                    if (w_access) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= MemWriteM;
                        r_mem_addr  <= ALUResultM;
                        r_mem_wdata <= WriteDataM;
                        r_mem_be    <= ByteEnM;
                        r_timer     <= 8'd0;
                        r_state     <= c_REQ;
                    end
                end

                c_REQ: begin
                    // Ack wins over timeout when both land on the same cycle.
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_read_data <= mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= c_DONE;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_mem_req   <= 1'b0;
                        r_read_data <= 32'd0;
                        r_fault     <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state   <= c_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Self-checking bench for dmem_access_ctrl. Accesses are
//               described at transaction level (kind, address, data, ack
//               delay) and the expected stall/request/fault/data behaviour
//               is derived from those parameters. A second instance with a
//               3-bit counter exercises stall counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  ByteEnM;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, ReadDataM;
    logic [3:0]  mem_be;
    logic        StallM, FlushW, FaultM;
    logic [31:0] StallCnt;

    logic        s_mem_req, s_mem_we;
    logic [31:0] s_mem_addr, s_mem_wdata, s_ReadDataM;
    logic [3:0]  s_mem_be;
    logic        s_StallM, s_FlushW, s_FaultM;
    logic [2:0]  s_StallCnt;

    int checks = 0;
    int errors = 0;

    // Reference state: stall cycles since reset and the load data M/W holds.
    int          m_cnt = 0;
    logic [31:0] m_rd  = 32'd0;

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ReadDataM(ReadDataM), .StallM(StallM),
        .FlushW(FlushW), .FaultM(FaultM), .StallCnt(StallCnt)
    );

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_be(s_mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ReadDataM(s_ReadDataM), .StallM(s_StallM),
        .FlushW(s_FlushW), .FaultM(s_FaultM), .StallCnt(s_StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] sat3(input int n);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

    // One memory access from the IDLE launch cycle through DONE.
    // dly = REQ cycle index of the ack; dly >= TO means no ack (timeout).
    task automatic do_access(input bit ld, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             input int dly, input logic [31:0] rd);
        bit acked;
        int nreq;
        int sel;
        acked = (dly < TO);
        nreq  = acked ? dly + 1 : TO;

        // Launch cycle.
        @(negedge clk);
        MemReadM = ld; MemWriteM = !ld;
        ALUResultM = addr; WriteDataM = wd; ByteEnM = be;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL launch_stall got=%b exp=1", StallM); end
        checks++; if (FlushW !== 1'b1) begin errors++; $display("FAIL launch_flush got=%b exp=1", FlushW); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL launch_req got=%b exp=0", mem_req); end
        checks++; if (StallCnt !== 32'(m_cnt)) begin errors++; $display("FAIL launch_cnt got=%0d exp=%0d", StallCnt, m_cnt); end
        m_cnt++;

        // Request cycles; M-stage inputs are scrambled to show they are ignored.
        for (int k = 0; k < nreq; k++) begin
            @(negedge clk);
            sel = $urandom_range(0, 2);
            MemReadM = (sel == 1); MemWriteM = (sel == 2);
            ALUResultM = $urandom; WriteDataM = $urandom; ByteEnM = 4'($urandom);
            mem_ack = acked && (k == dly);
            mem_rdata = (acked && (k == dly)) ? rd : $urandom;
            #1;
            checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL req_stall k=%0d got=%b exp=1", k, StallM); end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL req_req k=%0d got=%b exp=1", k, mem_req); end
            checks++; if (mem_we !== !ld) begin errors++; $display("FAIL req_we k=%0d got=%b exp=%b", k, mem_we, !ld); end
            checks++; if (mem_addr !== addr) begin errors++; $display("FAIL req_addr k=%0d got=%h exp=%h", k, mem_addr, addr); end
            checks++; if (mem_wdata !== wd) begin errors++; $display("FAIL req_wdata k=%0d got=%h exp=%h", k, mem_wdata, wd); end
            checks++; if (mem_be !== be) begin errors++; $display("FAIL req_be k=%0d got=%h exp=%h", k, mem_be, be); end
            checks++; if (ReadDataM !== m_rd) begin errors++; $display("FAIL req_rdata k=%0d got=%h exp=%h", k, ReadDataM, m_rd); end
            checks++; if (FaultM !== 1'b0) begin errors++; $display("FAIL req_fault k=%0d got=%b exp=0", k, FaultM); end
            checks++; if (StallCnt !== 32'(m_cnt)) begin errors++; $display("FAIL req_cnt k=%0d got=%0d exp=%0d", k, StallCnt, m_cnt); end
            m_cnt++;
        end

        if (acked && ld) m_rd = rd;
        else if (!acked) m_rd = 32'd0;

        // DONE cycle: pipeline released; stray ack and a new load are ignored.
        @(negedge clk);
        MemReadM = 1'($urandom_range(0, 1)); MemWriteM = 1'b0;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL done_stall got=%b exp=0", StallM); end
        checks++; if (FlushW !== 1'b0) begin errors++; $display("FAIL done_flush got=%b exp=0", FlushW); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL done_req got=%b exp=0", mem_req); end
        checks++; if (FaultM !== !acked) begin errors++; $display("FAIL done_fault got=%b exp=%b", FaultM, !acked); end
        checks++; if (ReadDataM !== m_rd) begin errors++; $display("FAIL done_rdata got=%h exp=%h", ReadDataM, m_rd); end
        checks++; if (StallCnt !== 32'(m_cnt)) begin errors++; $display("FAIL done_cnt got=%0d exp=%0d", StallCnt, m_cnt); end
        checks++; if (s_StallCnt !== sat3(m_cnt)) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", s_StallCnt, sat3(m_cnt)); end
        checks++; if (s_FaultM !== !acked) begin errors++; $display("FAIL sat_fault got=%b exp=%b", s_FaultM, !acked); end
    endtask

    task automatic idle_cycle(input logic ack);
        @(negedge clk);
        MemReadM = 1'b0; MemWriteM = 1'b0;
        ALUResultM = $urandom; mem_ack = ack; mem_rdata = $urandom;
        #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL idle_stall got=%b exp=0", StallM); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", mem_req); end
        checks++; if (FaultM !== 1'b0) begin errors++; $display("FAIL idle_fault got=%b exp=0", FaultM); end
        checks++; if (ReadDataM !== m_rd) begin errors++; $display("FAIL idle_rdata got=%h exp=%h", ReadDataM, m_rd); end
        checks++; if (StallCnt !== 32'(m_cnt)) begin errors++; $display("FAIL idle_cnt got=%0d exp=%0d", StallCnt, m_cnt); end
    endtask

    task automatic test_reset;
        reset = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0;
        ALUResultM = 32'h40; WriteDataM = 32'h0; ByteEnM = 4'hF;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", StallM); end
        checks++; if (FlushW !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b exp=0", FlushW); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (ReadDataM !== 32'd0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", ReadDataM); end
        checks++; if (FaultM !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", FaultM); end
        checks++; if (StallCnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", StallCnt); end
        reset = 1'b0; MemReadM = 1'b0;
        m_cnt = 0; m_rd = 32'd0;
        idle_cycle(1'b1);
    endtask

    task automatic test_load_first_ack;
        do_access(1'b1, 32'h100, 32'h0, 4'hF, 0, 32'hDEADBEEF);
        idle_cycle(1'b0);
    endtask

    task automatic test_store_wait3;
        do_access(1'b0, 32'h20, 32'h12345678, 4'hF, 3, 32'hCAFEF00D);
        idle_cycle(1'b0);
    endtask

    task automatic test_timeout;
        do_access(1'b1, 32'h300, 32'h0, 4'h3, TO, 32'h0);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
    endtask

    task automatic test_ack_on_timeout;
        do_access(1'b1, 32'h44, 32'h0, 4'hC, TO - 1, 32'hA5A55A5A);
        idle_cycle(1'b0);
    endtask

    task automatic test_back_to_back;
        int base;
        base = m_cnt;
        do_access(1'b1, 32'h0, 32'h0, 4'hF, 0, 32'h11111111);
        do_access(1'b1, 32'h4, 32'h0, 4'hF, 0, 32'h22222222);
        idle_cycle(1'b0);
        checks++; if (StallCnt !== 32'(base + 4)) begin errors++; $display("FAIL b2b_cnt got=%0d exp=%0d", StallCnt, base + 4); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            do_access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                      $urandom_range(0, TO + 1), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h80; mem_ack = 1'b0;
        @(negedge clk);
        MemReadM = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_pre got=%b exp=1", mem_req); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL mid_stall_in_rst got=%b exp=0", StallM); end
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1;
        m_cnt = 0; m_rd = 32'd0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req got=%b exp=0", mem_req); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL mid_stall got=%b exp=0", StallM); end
        checks++; if (StallCnt !== 32'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", StallCnt); end
        checks++; if (s_StallCnt !== 3'd0) begin errors++; $display("FAIL mid_sat_cnt got=%0d exp=0", s_StallCnt); end
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        do_access(1'b1, 32'h84, 32'h0, 4'hF, 1, 32'h600DF00D);
        idle_cycle(1'b0);
    endtask

    initial begin
        test_reset();
        test_load_first_ack();
        test_store_wait3();
        test_timeout();
        test_ack_on_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
